sram_burst_seq: RTL and testbench

Sequencer for the serially loaded SRAM address register and the SRAM strobes on the cartridge CPLD. On a host command it shifts a start address MSB-first into the address register, then runs a burst of read or write accesses, pulsing the register's increment input after each one. It arbitrates the SRAM bus against the console (`snes_req`), granting it only between accesses.

---
 rtl/sram_burst_seq_if.sv | 40 ++++
 rtl/sram_burst_seq.sv | 154 +++++++++++++++
 tb/tb_sram_burst_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_seq_if.sv
// rtl/sram_burst_seq_if.sv - host command, address-register and SRAM strobe bundle for sram_burst_seq
//
// Host command side:   start, cmd_write, start_addr, burst_len, abort -> sequencer
//                      busy, done <- sequencer
// Console arbitration: snes_req -> sequencer, snes_gnt <- sequencer
// Address register:    sr_in, sr_en_n (shift, active-low), sr_counter_n (increment, active-low)
// SRAM:                mem_oe_n, mem_we_n (active-low strobes), data_strobe (last strobe cycle)
// modport slave is the sequencer, modport master is the host/bench.
interface sram_burst_seq_if #(
    parameter int AWIDTH = 21,
    parameter int LWIDTH = 16
);
    logic              start;
    logic              cmd_write;
    logic [AWIDTH-1:0] start_addr;
    logic [LWIDTH-1:0] burst_len;
    logic              abort;
    logic              snes_req;
    logic              busy;
    logic              done;
    logic              sr_in;
    logic              sr_en_n;
    logic              sr_counter_n;
    logic              mem_oe_n;
    logic              mem_we_n;
    logic              data_strobe;
    logic              snes_gnt;

    modport master (
        output start, cmd_write, start_addr, burst_len, abort, snes_req,
        input  busy, done, sr_in, sr_en_n, sr_counter_n, mem_oe_n, mem_we_n,
               data_strobe, snes_gnt
    );

    modport slave (
        input  start, cmd_write, start_addr, burst_len, abort, snes_req,
        output busy, done, sr_in, sr_en_n, sr_counter_n, mem_oe_n, mem_we_n,
               data_strobe, snes_gnt
    );
endinterface

// File: rtl/sram_burst_seq.sv
// rtl/sram_burst_seq.sv - serial SRAM address loader and burst strobe sequencer with console arbitration
//
// Ports:
//   clk    - single clock
//   rst_n  - synchronous active-low reset
//   bus    - sram_burst_seq_if.slave: host command in (start, cmd_write, start_addr,
//            burst_len, abort), status out (busy, done), serial address register
//            drive (sr_in, sr_en_n, sr_counter_n), SRAM strobes (mem_oe_n, mem_we_n,
//            data_strobe) and console arbitration (snes_req in, snes_gnt out).
//
// Every output is a flop loaded from the next-state value, so the outputs seen in a
// cycle always describe the state the sequencer is in during that cycle.
module sram_burst_seq #(
    parameter int AWIDTH   = 21,
    parameter int LWIDTH   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_burst_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_INC    = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int BW = (AWIDTH > 1) ? $clog2(AWIDTH) : 1;
    localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [WW-1:0]     wait_cnt;
    logic [WW-1:0]     wait_nxt;
    logic [LWIDTH-1:0] remain;
    logic [AWIDTH-1:0] addr_sh;
    logic              wr;
    logic              shift_last;
    logic              access_last;

    always_comb begin
        state_nxt   = state;
        shift_last  = (bit_cnt == BW'(AWIDTH - 1));
        access_last = (wait_cnt == WW'(WAIT_CYC - 1));
        case (state)
            S_IDLE: begin
                // A start that collides with a console request is simply dropped.
                if (bus.start && !bus.snes_req) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.abort) begin
                    state_nxt = S_DONE;
                end else if (shift_last) begin
                    if (remain == '0) begin
                        state_nxt = S_DONE;
                    end else if (bus.snes_req) begin
                        state_nxt = S_HOLD;
                    end else begin
                        state_nxt = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (bus.abort) begin
                    state_nxt = S_DONE;
                end else if (access_last) begin
                    state_nxt = S_INC;
                end
            end
            S_INC: begin
                // remain still holds the pre-decrement count here.
                if (bus.abort || remain == LWIDTH'(1)) begin
                    state_nxt = S_DONE;
                end else if (bus.snes_req) begin
                    state_nxt = S_HOLD;
                end else begin
                    state_nxt = S_ACCESS;
                end
            end
            S_HOLD: begin
                if (bus.abort) begin
                    state_nxt = S_DONE;
                end else if (!bus.snes_req) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        wait_nxt = (state == S_ACCESS && state_nxt == S_ACCESS) ? wait_cnt + WW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            bit_cnt          <= '0;
            wait_cnt         <= '0;
            remain           <= '0;
            addr_sh          <= '0;
            wr               <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.sr_in        <= 1'b0;
            bus.sr_en_n      <= 1'b1;
            bus.sr_counter_n <= 1'b1;
            bus.mem_oe_n     <= 1'b1;
            bus.mem_we_n     <= 1'b1;
            bus.data_strobe  <= 1'b0;
            bus.snes_gnt     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            bit_cnt  <= (state == S_SHIFT && state_nxt == S_SHIFT) ? bit_cnt + BW'(1) : '0;

            // The first serial bit comes straight from the command inputs; the
            // remaining bits come out of the MSB of a left-shifting copy.
            if (state == S_IDLE && state_nxt == S_SHIFT) begin
                wr        <= bus.cmd_write;
                remain    <= bus.burst_len;
                addr_sh   <= bus.start_addr << 1;
                bus.sr_in <= bus.start_addr[AWIDTH-1];
            end else if (state == S_SHIFT && state_nxt == S_SHIFT) begin
                addr_sh   <= addr_sh << 1;
                bus.sr_in <= addr_sh[AWIDTH-1];
            end else begin
                bus.sr_in <= 1'b0;
            end

            if (state == S_INC) begin
                remain <= remain - LWIDTH'(1);
            end

            bus.busy         <= (state_nxt == S_SHIFT) || (state_nxt == S_ACCESS) ||
                                (state_nxt == S_INC)   || (state_nxt == S_HOLD);
            bus.done         <= (state_nxt == S_DONE);
            bus.sr_en_n      <= !(state_nxt == S_SHIFT);
            bus.sr_counter_n <= !(state_nxt == S_INC);
            bus.mem_oe_n     <= !(state_nxt == S_ACCESS && !wr);
            bus.mem_we_n     <= !(state_nxt == S_ACCESS && wr);
            bus.data_strobe  <= (state_nxt == S_ACCESS) && (wait_nxt == WW'(WAIT_CYC - 1));
            // In IDLE the grant mirrors the request one cycle late; inside a
            // command it is only given in HOLD, i.e. between accesses.
            bus.snes_gnt     <= (state_nxt == S_HOLD) || (state_nxt == S_IDLE && bus.snes_req);
        end
    end
endmodule

// File: tb/tb_sram_burst_seq.sv
// tb/tb_sram_burst_seq.sv - self-checking bench for sram_burst_seq
module tb_sram_burst_seq;
    localparam int AW   = 21;
    localparam int LW   = 16;
    localparam int W    = 2;
    localparam int MAXC = 512;

    // Output vector bit order: busy, done, sr_en_n, sr_in, sr_counter_n, mem_oe_n, mem_we_n, data_strobe, snes_gnt
    localparam logic [8:0] RST_V  = 9'b0_0_1_0_1_1_1_0_0;
    localparam logic [8:0] ACT_V  = 9'b1_0_1_0_1_1_1_0_0;
    localparam logic [8:0] DONE_V = 9'b0_1_1_0_1_1_1_0_0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_burst_seq_if #(.AWIDTH(AW), .LWIDTH(LW)) bus ();

    sram_burst_seq #(.AWIDTH(AW), .LWIDTH(LW), .WAIT_CYC(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    bit         req_tr[MAXC];
    logic [8:0] exp_v[MAXC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] obs_v();
        return {bus.busy, bus.done, bus.sr_en_n, bus.sr_in, bus.sr_counter_n,
                bus.mem_oe_n, bus.mem_we_n, bus.data_strobe, bus.snes_gnt};
    endfunction

    task automatic clear_req();
        for (int i = 0; i < MAXC; i++) req_tr[i] = 1'b0;
    endtask

    task automatic random_req();
        int c;
        int run;
        clear_req();
        c = 1;
        while (c < MAXC - 8) begin
            if ($urandom_range(0, 5) == 0) begin
                run = $urandom_range(1, 3);
                for (int j = 0; j < run; j++) req_tr[c + j] = 1'b1;
                c = c + run + 1;
            end else begin
                c = c + 1;
            end
        end
    endtask

    // Expected per-cycle outputs from the schedule rules: cycle c is the cycle after edge c-1,
    // start is sampled at edge 0, and a decision at the end of cycle d uses req_tr[d].
    task automatic build_model(input bit wr, input logic [AW-1:0] addr, input int len,
                               input int abort_c, output int done_c, output bit cut);
        int         d;
        int         c;
        logic [8:0] v;
        cut = 1'b0;
        for (int i = 0; i < MAXC; i++) exp_v[i] = RST_V;
        for (int i = 0; i < AW; i++) begin
            v = ACT_V;
            v[6] = 1'b0;
            v[5] = addr[AW-1-i];
            exp_v[1 + i] = v;
        end
        d = AW;
        for (int k = 0; k < len; k++) begin
            c = d + 1;
            while (c < MAXC - 8 && req_tr[c - 1]) begin
                v = ACT_V;
                v[0] = 1'b1;
                exp_v[c] = v;
                c++;
            end
            for (int j = 0; j < W; j++) begin
                v = ACT_V;
                if (wr) v[2] = 1'b0; else v[3] = 1'b0;
                v[1] = (j == W - 1);
                exp_v[c + j] = v;
            end
            v = ACT_V;
            v[4] = 1'b0;
            exp_v[c + W] = v;
            d = c + W;
        end
        done_c = d + 1;
        if (abort_c >= 1 && abort_c < done_c) begin
            for (int i = abort_c + 1; i <= done_c; i++) exp_v[i] = RST_V;
            done_c = abort_c + 1;
            cut = 1'b1;
        end
        exp_v[done_c] = DONE_V;
        exp_v[done_c + 1] = RST_V | {8'b0, req_tr[done_c]};
    endtask

    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input int len,
                           input int abort_c, input int rst_c, output int done_seen);
        int             done_c;
        int             last;
        int             incs;
        bit             cut;
        bit             ok;
        logic [AW-1:0]  mreg;
        logic [AW-1:0]  exp_a;
        build_model(wr, addr, len, abort_c, done_c, cut);
        last = done_c + 1;
        if (rst_c >= 1 && rst_c <= done_c) begin
            for (int i = rst_c + 1; i < MAXC; i++) exp_v[i] = RST_V;
            last = rst_c + 1;
            cut = 1'b1;
        end
        mreg = '0;
        incs = 0;
        done_seen = -1;
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.cmd_write  = wr;
        bus.start_addr = addr;
        bus.burst_len  = LW'(len);
        bus.snes_req   = req_tr[0];
        bus.abort      = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                bus.start    = 1'b0;
                bus.snes_req = req_tr[c];
                bus.abort    = (c == abort_c);
                rst_n        = !(c == rst_c);
            end
            @(negedge clk);
            if (c >= 1) begin
                chk($sformatf("cyc%0d", c), 32'(obs_v()), 32'(exp_v[c]));
                ok = !(!bus.mem_oe_n && !bus.mem_we_n);
                ok = ok && !((!bus.mem_oe_n || !bus.mem_we_n) && (!bus.sr_en_n || !bus.sr_counter_n));
                ok = ok && !(bus.snes_gnt && (!bus.mem_oe_n || !bus.mem_we_n || !bus.sr_en_n || !bus.sr_counter_n));
                chk($sformatf("mutex%0d", c), 32'(ok), 32'd1);
            end
            if (bus.done && done_seen < 0) done_seen = c;
            if (!bus.sr_en_n) mreg = {mreg[AW-2:0], bus.sr_in};
            if (!bus.sr_counter_n) begin
                mreg = mreg + AW'(1);
                incs++;
            end
        end
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.snes_req = 1'b0;
        rst_n        = 1'b1;
        if (!cut) begin
            exp_a = addr + AW'(len);
            chk("incs", 32'(incs), 32'(len));
            chk("addr", 32'(mreg), 32'(exp_a));
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int         ds;
        logic [AW-1:0] ra;
        bus.start      = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.start_addr = '0;
        bus.burst_len  = '0;
        bus.abort      = 1'b0;
        bus.snes_req   = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_reset", 32'(obs_v()), 32'(RST_V));
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), 32'(obs_v()), 32'(RST_V));
        end

        clear_req();
        run_cmd(1'b0, 21'h12345, 3, -1, -1, ds);
        chk("rd_done_cyc", 32'(ds), 32'd31);

        run_cmd(1'b1, 21'h1ABCDE, 0, -1, -1, ds);
        chk("l0_done_cyc", 32'(ds), 32'd22);

        for (int i = 27; i <= 30; i++) req_tr[i] = 1'b1;
        run_cmd(1'b0, 21'h00F0F, 3, -1, -1, ds);
        chk("hold_done_cyc", 32'(ds), 32'd35);
        clear_req();

        @(posedge clk);
        #1;
        bus.snes_req = 1'b1;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("req_busy%0d", i), 32'(bus.busy), 32'd0);
            chk($sformatf("req_gnt%0d", i), 32'(bus.snes_gnt), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.snes_req = 1'b0;
        repeat (2) @(posedge clk);

        run_cmd(1'b1, 21'h0AAAA, 2, 10, -1, ds);
        chk("abort_done_cyc", 32'(ds), 32'd11);

        run_cmd(1'b0, 21'h12345, 3, -1, 23, ds);

        for (int it = 0; it < 24; it++) begin
            random_req();
            ra = AW'($urandom);
            run_cmd(1'($urandom), ra, $urandom_range(0, 6),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1, -1, ds);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
